// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory port between an instruction-side and a
// data-side master. One transaction is outstanding at a time. Contention is
// resolved either by fixed data-side priority or by alternating grants. The
// port that was just served is ignored for one idle cycle so that the other
// port gets a chance to be granted.
module memory_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read_request,
  input  logic        i_write_request,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  output logic        i_response,
  output logic [31:0] i_read_data,
  input  logic        d_read_request,
  input  logic        d_write_request,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_write_data,
  output logic        d_response,
  output logic [31:0] d_read_data,
  output logic        memory_read_request,
  output logic        memory_write_request,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_write_data,
  input  logic        memory_response,
  input  logic [31:0] memory_read_data
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t      r_state;
  logic        r_sel_d;        // port owning the current transaction (1 = D)
  logic        r_last_d;       // last granted port, 0 after reset so D wins first
  logic        r_mask_i;
  logic        r_mask_d;
  logic        r_is_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic        r_i_response;
  logic        r_d_response;
  logic [31:0] r_i_read_data;
  logic [31:0] r_d_read_data;

  logic        w_i_req;
  logic        w_d_req;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_op_write;

  // A port only counts as requesting when it is not masked after being served.
  assign w_i_req = (i_read_request | i_write_request) & ~r_mask_i;
  assign w_d_req = (d_read_request | d_write_request) & ~r_mask_d;

  // D wins when alone, always under fixed priority, or when I was granted last.
  assign w_grant_d = w_d_req & (~w_i_req | (ROUND_ROBIN == 1'b0) | ~r_last_d);
  assign w_grant_i = w_i_req & ~w_grant_d;

  // Write takes precedence over read when a master raises both.
  assign w_op_write = w_grant_d ? d_write_request : i_write_request;

  assign memory_read_request  = r_mem_rd;
  assign memory_write_request = r_mem_wr;
  assign memory_addr          = r_addr;
  assign memory_write_data    = r_wdata;
  assign i_response           = r_i_response;
  assign i_read_data          = r_i_read_data;
  assign d_response           = r_d_response;
  assign d_read_data          = r_d_read_data;

  // Arbitration FSM with registered memory-side and port-side outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_sel_d       <= 1'b0;
      r_last_d      <= 1'b0;
      r_mask_i      <= 1'b0;
      r_mask_d      <= 1'b0;
      r_is_write    <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_i_response  <= 1'b0;
      r_d_response  <= 1'b0;
      r_i_read_data <= '0;
      r_d_read_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // The mask only lives for the single idle cycle after DONE.
          r_mask_i <= 1'b0;
          r_mask_d <= 1'b0;
          if (w_grant_d || w_grant_i) begin
            r_sel_d    <= w_grant_d;
            r_last_d   <= w_grant_d;
            r_addr     <= w_grant_d ? d_addr : i_addr;
            r_wdata    <= w_grant_d ? d_write_data : i_write_data;
            r_is_write <= w_op_write;
            r_mem_rd   <= ~w_op_write;
            r_mem_wr   <= w_op_write;
            r_state    <= w_grant_d ? BUSY_D : BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          if (memory_response) begin
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_i_response  <= ~r_sel_d;
            r_d_response  <= r_sel_d;
            r_i_read_data <= (r_sel_d || r_is_write) ? '0 : memory_read_data;
            r_d_read_data <= (!r_sel_d || r_is_write) ? '0 : memory_read_data;
            r_state       <= DONE;
          end
        end
        DONE: begin
          r_i_response  <= 1'b0;
          r_d_response  <= 1'b0;
          r_i_read_data <= '0;
          r_d_read_data <= '0;
          r_mask_d      <= r_sel_d;
          r_mask_i      <= ~r_sel_d;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: a round-robin instance (u_rr) and a fixed
// priority instance (u_fx), each with a small memory responder, auto-dropping
// masters and a queue-based scoreboard of expected transactions.
module tb_memory_arbiter;

  typedef struct {
    bit          port_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gap;     // expected cycles from previous port response to memory request, -1 = any
  } txn_t;

  logic clk;
  logic reset;

  logic        i_rr, i_wr, i_rsp, d_rr, d_wr, d_rsp;
  logic [31:0] i_addr, i_wd, i_rd, d_addr, d_wd, d_rd;
  logic        m_rr, m_wr, m_rsp;
  logic [31:0] m_addr, m_wd, m_rdata;

  logic        b_i_rr, b_i_wr, b_i_rsp, b_d_rr, b_d_wr, b_d_rsp;
  logic [31:0] b_i_addr, b_i_wd, b_i_rd, b_d_addr, b_d_wd, b_d_rd;
  logic        b_m_rr, b_m_wr, b_m_rsp;
  logic [31:0] b_m_addr, b_m_wd, b_m_rdata;

  txn_t exp_q[$];
  txn_t exp1_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   mem_delay = 1;
  bit   force_pulse = 0;
  int   i_hold = 0, d_hold = 0, b_i_hold = 0, b_d_hold = 0;

  memory_arbiter #(.ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .i_read_request(i_rr), .i_write_request(i_wr), .i_addr(i_addr), .i_write_data(i_wd),
    .i_response(i_rsp), .i_read_data(i_rd),
    .d_read_request(d_rr), .d_write_request(d_wr), .d_addr(d_addr), .d_write_data(d_wd),
    .d_response(d_rsp), .d_read_data(d_rd),
    .memory_read_request(m_rr), .memory_write_request(m_wr), .memory_addr(m_addr),
    .memory_write_data(m_wd), .memory_response(m_rsp), .memory_read_data(m_rdata)
  );

  memory_arbiter #(.ROUND_ROBIN(1'b0)) u_fx (
    .clk(clk), .reset(reset),
    .i_read_request(b_i_rr), .i_write_request(b_i_wr), .i_addr(b_i_addr), .i_write_data(b_i_wd),
    .i_response(b_i_rsp), .i_read_data(b_i_rd),
    .d_read_request(b_d_rr), .d_write_request(b_d_wr), .d_addr(b_d_addr), .d_write_data(b_d_wd),
    .d_response(b_d_rsp), .d_read_data(b_d_rd),
    .memory_read_request(b_m_rr), .memory_write_request(b_m_wr), .memory_addr(b_m_addr),
    .memory_write_data(b_m_wd), .memory_response(b_m_rsp), .memory_read_data(b_m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic push(input bit which, input bit pd, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int gap);
    txn_t t;
    t.port_d = pd; t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rd; t.gap = gap;
    if (which) exp1_q.push_back(t);
    else exp_q.push_back(t);
  endtask

  task automatic drain(input bit which, input int budget);
    int n = 0;
    while (((which ? exp1_q.size() : exp_q.size()) != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(which ? "drain_fx" : "drain_rr", 32'(which ? exp1_q.size() : exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Memory responder for the round-robin instance; write cycles return junk data.
  initial begin
    int mcnt = 0;
    m_rsp = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      m_rsp = 1'b0; m_rdata = '0;
      if (force_pulse) begin
        m_rsp = 1'b1; m_rdata = 32'hBAD0BAD0; force_pulse = 0;
      end else if (m_rr || m_wr) begin
        if (mcnt >= mem_delay) begin
          m_rsp = 1'b1; m_rdata = m_rr ? mem_data(m_addr) : 32'hFFFFFFFF; mcnt = 0;
        end else mcnt++;
      end else mcnt = 0;
    end
  end

  // Memory responder for the fixed-priority instance, one wait cycle.
  initial begin
    int bcnt = 0;
    b_m_rsp = 1'b0; b_m_rdata = '0;
    forever begin
      @(negedge clk);
      b_m_rsp = 1'b0; b_m_rdata = '0;
      if (b_m_rr || b_m_wr) begin
        if (bcnt >= 1) begin
          b_m_rsp = 1'b1; b_m_rdata = mem_data(b_m_addr); bcnt = 0;
        end else bcnt++;
      end else bcnt = 0;
    end
  end

  // Masters drop their request after the programmed number of responses.
  initial forever begin
    @(negedge clk);
    if (i_rsp && i_hold > 0) begin i_hold--; if (i_hold == 0) begin i_rr = 0; i_wr = 0; end end
    if (d_rsp && d_hold > 0) begin d_hold--; if (d_hold == 0) begin d_rr = 0; d_wr = 0; end end
    if (b_i_rsp && b_i_hold > 0) begin b_i_hold--; if (b_i_hold == 0) b_i_rr = 0; end
    if (b_d_rsp && b_d_hold > 0) begin b_d_hold--; if (b_d_hold == 0) b_d_rr = 0; end
  end

  // Scoreboard monitor for the round-robin instance.
  initial begin
    bit          in_txn = 0;
    logic [31:0] first_addr = '0, first_wd = '0;
    int          last_mrsp = -100, last_prsp = -100;
    txn_t        e;
    forever begin
      @(negedge clk);
      chk("mem_excl", 32'(m_rr & m_wr), 32'd0);
      if (m_rr || m_wr) begin
        if (!in_txn) begin
          in_txn = 1; first_addr = m_addr; first_wd = m_wd;
          if (exp_q.size() == 0) chk("mem_unexp", 32'd1, 32'd0);
          else begin
            chk("mem_wr", 32'(m_wr), 32'(exp_q[0].wr));
            chk("mem_rd", 32'(m_rr), 32'(!exp_q[0].wr));
            chk("mem_addr", m_addr, exp_q[0].addr);
            if (exp_q[0].wr) chk("mem_wdata", m_wd, exp_q[0].wdata);
            if (exp_q[0].gap >= 0) chk("grant_gap", 32'(cyc - last_prsp), 32'(exp_q[0].gap));
          end
        end else begin
          chk("mem_addr_hold", m_addr, first_addr);
          chk("mem_wd_hold", m_wd, first_wd);
        end
      end else in_txn = 0;
      if (i_rsp && d_rsp) chk("rsp_both", 32'd1, 32'd0);
      if (!i_rsp) chk("i_rd_quiet", i_rd, 32'd0);
      if (!d_rsp) chk("d_rd_quiet", d_rd, 32'd0);
      if (i_rsp || d_rsp) begin
        chk("rsp_latency", 32'(cyc - last_mrsp), 32'd1);
        last_prsp = cyc;
        if (exp_q.size() == 0) chk("rsp_unexp", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_port", 32'(d_rsp), 32'(e.port_d));
          chk("rsp_data", d_rsp ? d_rd : i_rd, e.rdata);
        end
      end
      if (m_rsp) last_mrsp = cyc;
    end
  end

  // Scoreboard monitor for the fixed-priority instance.
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (b_i_rsp || b_d_rsp) begin
        if (exp1_q.size() == 0) chk("fx_rsp_unexp", 32'd1, 32'd0);
        else begin
          e = exp1_q.pop_front();
          chk("fx_rsp_port", 32'(b_d_rsp), 32'(e.port_d));
          chk("fx_rsp_data", b_d_rsp ? b_d_rd : b_i_rd, e.rdata);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    i_rr = 0; i_wr = 0; i_addr = '0; i_wd = '0;
    d_rr = 0; d_wr = 0; d_addr = '0; d_wd = '0;
    b_i_rr = 0; b_i_wr = 0; b_i_addr = '0; b_i_wd = '0;
    b_d_rr = 0; b_d_wr = 0; b_d_addr = '0; b_d_wd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {i_rsp, d_rsp, m_rr, m_wr, 28'd0}, 32'd0);
    chk("rst_data", i_rd | d_rd | m_addr | m_wd, 32'd0);
    chk("rst_fx_outputs", {b_i_rsp, b_d_rsp, b_m_rr, b_m_wr, 28'd0}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // D read, three wait cycles, checked first-cycle latency
    mem_delay = 3;
    @(posedge clk); #1;
    push(0, 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, -1);
    d_addr = 32'h100; d_rr = 1; d_hold = 1;
    @(negedge clk); chk("rd_c0_mreq", 32'(m_rr), 32'd0);
    @(negedge clk); chk("rd_c1_mreq", 32'(m_rr), 32'd1); chk("rd_c1_addr", m_addr, 32'h100);
    drain(0, 40);

    // D write with read also raised
    mem_delay = 2;
    @(posedge clk); #1;
    push(0, 1, 1, 32'h200, 32'h12345678, 32'h0, -1);
    d_addr = 32'h200; d_wd = 32'h12345678; d_wr = 1; d_rr = 1; d_hold = 1;
    drain(0, 40);

    // I read, master changes address while the transaction is in flight
    mem_delay = 4;
    @(posedge clk); #1;
    push(0, 0, 0, 32'h400, 32'h0, mem_data(32'h400), -1);
    i_addr = 32'h400; i_rr = 1; i_hold = 1;
    repeat (2) @(posedge clk); #1 i_addr = 32'h999;
    @(negedge clk); chk("addr_stable", m_addr, 32'h400);
    drain(0, 40);

    // Contention after reset, both held: D, I, D, I
    do_reset();
    mem_delay = 1;
    @(posedge clk); #1;
    push(0, 1, 0, 32'h10, 32'h0, mem_data(32'h10), -1);
    push(0, 0, 0, 32'h20, 32'h0, mem_data(32'h20), 2);
    push(0, 1, 0, 32'h10, 32'h0, mem_data(32'h10), 2);
    push(0, 0, 0, 32'h20, 32'h0, mem_data(32'h20), 2);
    d_addr = 32'h10; i_addr = 32'h20; d_wr = 0; d_rr = 1; i_rr = 1; d_hold = 2; i_hold = 2;
    drain(0, 80);

    // D held alone: the served port waits out the masked idle cycle
    @(posedge clk); #1;
    push(0, 1, 0, 32'h50, 32'h0, mem_data(32'h50), -1);
    push(0, 1, 0, 32'h50, 32'h0, mem_data(32'h50), 3);
    d_addr = 32'h50; d_rr = 1; d_hold = 2;
    drain(0, 60);

    // Stray memory response while idle
    @(posedge clk); #1 force_pulse = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_pulse_rsp", 32'({i_rsp, d_rsp}), 32'd0);
      chk("idle_pulse_mreq", 32'({m_rr, m_wr}), 32'd0);
    end

    // Reset during BUSY_D, then a late memory response, then a normal I read
    mem_delay = 20;
    @(posedge clk); #1;
    push(0, 1, 0, 32'h300, 32'h0, mem_data(32'h300), -1);
    d_addr = 32'h300; d_rr = 1; d_hold = 1;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0; d_rr = 0; d_hold = 0;
    @(posedge clk); #1;
    reset = 1'b1; exp_q.delete();
    @(negedge clk);
    chk("midrst_outputs", {i_rsp, d_rsp, m_rr, m_wr, 28'd0}, 32'd0);
    chk("midrst_data", i_rd | d_rd | m_addr | m_wd, 32'd0);
    @(posedge clk); #1 force_pulse = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_rsp_quiet", 32'({i_rsp, d_rsp, m_rr, m_wr}), 32'd0);
    end
    mem_delay = 2;
    @(posedge clk); #1;
    push(0, 0, 0, 32'h500, 32'h0, mem_data(32'h500), -1);
    i_addr = 32'h500; i_rr = 1; i_hold = 1;
    @(negedge clk); chk("post_rst_c0", 32'(m_rr), 32'd0);
    @(negedge clk); chk("post_rst_c1", 32'(m_rr), 32'd1); chk("post_rst_addr", m_addr, 32'h500);
    drain(0, 40);

    // Fixed priority: contention after reset, then contention after a D grant
    do_reset();
    @(posedge clk); #1;
    push(1, 1, 0, 32'h30, 32'h0, mem_data(32'h30), -1);
    push(1, 0, 0, 32'h40, 32'h0, mem_data(32'h40), -1);
    b_d_addr = 32'h30; b_i_addr = 32'h40; b_d_rr = 1; b_i_rr = 1; b_d_hold = 1; b_i_hold = 1;
    drain(1, 60);
    @(posedge clk); #1;
    push(1, 1, 0, 32'h600, 32'h0, mem_data(32'h600), -1);
    b_d_addr = 32'h600; b_d_rr = 1; b_d_hold = 1;
    drain(1, 60);
    @(posedge clk); #1;
    push(1, 1, 0, 32'h700, 32'h0, mem_data(32'h700), -1);
    push(1, 0, 0, 32'h800, 32'h0, mem_data(32'h800), -1);
    b_d_addr = 32'h700; b_i_addr = 32'h800; b_d_rr = 1; b_i_rr = 1; b_d_hold = 1; b_i_hold = 1;
    drain(1, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
